// File: rtl/reduce_tree_pipe.sv
// Pipelined N_IN-input reduction tree (AND/OR/XOR/NAND) with per-bit masking,
// one register per tree level, valid/ready on both sides and a global stall.
module reduce_tree_pipe #(
  parameter int N_IN = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_data,
  input  logic [N_IN-1:0] in_mask,
  input  logic [1:0]      in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_result,
  output logic [1:0]      out_op
);

  // Handshake: a beat moves on a side when its valid and ready are both high
  // at a rising edge. in_ready = adv, and adv depends only on the output side,
  // so every stage advances together or holds together.

  localparam int LAT = $clog2(N_IN);
  localparam int TOT = 2 * N_IN - 1;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  // All tree levels share one flat vector; level k starts at this bit offset.
  function automatic int lvl_off(input int k);
    return 2 * N_IN - 2 * (N_IN >> k);
  endfunction

  logic [TOT-1:0]        tree_q;
  logic [TOT-1:0]        tree_d;
  logic [LAT:0][1:0]     op_q;
  logic [LAT:0]          vld_q;
  logic                  adv;
  logic                  ident;
  logic                  g_a;
  logic                  g_b;
  logic                  g_r;

  assign adv      = ~vld_q[LAT] | out_ready;
  assign in_ready = adv;
  assign ident    = ~(in_op[1] ^ in_op[0]);

  always_comb begin
    tree_d = '0;
    g_a    = 1'b0;
    g_b    = 1'b0;
    g_r    = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      tree_d[i] = in_mask[i] ? in_data[i] : ident;
    end
    for (int k = 1; k <= LAT; k++) begin
      for (int j = 0; j < (N_IN >> k); j++) begin
        g_a = tree_q[lvl_off(k-1) + 2*j];
        g_b = tree_q[lvl_off(k-1) + 2*j + 1];
        case (op_q[k-1])
          OP_OR:   g_r = g_a | g_b;
          OP_XOR:  g_r = g_a ^ g_b;
          default: g_r = g_a & g_b;
        endcase
        // NAND is an AND tree; the inversion happens only on the root bit.
        if (k == LAT && op_q[k-1] == OP_NAND) begin
          g_r = ~g_r;
        end
        tree_d[lvl_off(k) + j] = g_r;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tree_q <= '0;
      op_q   <= '0;
      vld_q  <= '0;
    end else if (adv) begin
      tree_q <= tree_d;
      op_q   <= {op_q[LAT-1:0], in_op};
      vld_q  <= {vld_q[LAT-1:0], in_valid};
    end
  end

  assign out_valid  = vld_q[LAT];
  assign out_op     = op_q[LAT];
  assign out_result = tree_q[TOT-1];

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Self-checking bench for reduce_tree_pipe (N_IN=8): directed scenarios plus a
// random stream, checked through an expected-result queue.
module tb_reduce_tree_pipe;

  localparam int N   = 8;
  localparam int LAT = 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [N-1:0] in_mask;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic         out_result;
  logic [1:0]   out_op;

  reduce_tree_pipe #(.N_IN(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mask    (in_mask),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op)
  );

  // clock / reset / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  // stimulus entry: {expected_result, op, mask, data}
  logic [2*N+2:0] stim_q[$];
  logic [2:0]     exp_q[$];
  int             exp_cyc_q[$];

  function automatic logic model(input logic [1:0] op, input logic [N-1:0] d,
                                 input logic [N-1:0] m);
    case (op)
      2'b00:   return &(d | ~m);
      2'b01:   return |(d & m);
      2'b10:   return ^(d & m);
      default: return ~(&(d | ~m));
    endcase
  endfunction

  task automatic add_beat(input logic [1:0] op, input logic [N-1:0] d,
                          input logic [N-1:0] m, input logic exp);
    stim_q.push_back({exp, op, m, d});
  endtask

  // driver: called just after a falling edge, sets inputs for the next rising edge
  task automatic drive_cycle(input logic ordy, input logic allow_in);
    logic [2*N+2:0] s;
    out_ready = ordy;
    if (allow_in && stim_q.size() > 0) begin
      s = stim_q[0];
      in_valid = 1'b1;
      {in_op, in_mask, in_data} = s[2*N+1:0];
    end else begin
      in_valid = 1'b0;
      in_op    = 2'($urandom_range(0, 3));
      in_data  = 8'($urandom_range(0, 255));
      in_mask  = 8'($urandom_range(0, 255));
    end
    #1;
    if (in_valid && in_ready) begin
      s = stim_q.pop_front();
      exp_q.push_back({s[2*N+1:2*N], s[2*N+2]});
      exp_cyc_q.push_back(cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_mask = '0; in_op = 2'b00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_result !== 1'b0 || out_op !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b r=%b op=%b, want 0 0 00", out_valid, out_result, out_op);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  // Streams stim_q with out_ready=1 and checks results and LAT+1 latency.
  task automatic test_stream(input string name);
    int guard = 0;
    logic [2:0] e;
    int c;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && guard < 200) begin
      @(negedge clk);
      drive_cycle(1'b1, 1'b1);
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_extra: unexpected beat op=%b r=%b", name, out_op, out_result);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          if ({out_op, out_result} !== e) begin
            n_fail++;
            $display("FAIL %s_result: got op=%b r=%b, want op=%b r=%b", name, out_op, out_result, e[2:1], e[0]);
          end
          n_cmp++;
          if (cyc - c != LAT + 1) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d, want %0d", name, cyc - c, LAT + 1);
          end
        end
      end
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: %0d results outstanding, want 0", name, exp_q.size());
    end
  endtask

  task automatic test_and();
    add_beat(2'b00, 8'hFF, 8'hFF, 1'b1);
    add_beat(2'b00, 8'hFE, 8'hFF, 1'b0);
    test_stream("and");
  endtask

  task automatic test_xor_stream();
    add_beat(2'b10, 8'h01, 8'hFF, 1'b1);
    add_beat(2'b10, 8'h03, 8'hFF, 1'b0);
    add_beat(2'b10, 8'h07, 8'hFF, 1'b1);
    test_stream("xor");
  endtask

  task automatic test_mask();
    add_beat(2'b00, 8'h0F, 8'h0F, 1'b1);
    add_beat(2'b01, 8'hF0, 8'h0F, 1'b0);
    add_beat(2'b11, 8'h5A, 8'h00, 1'b0);
    add_beat(2'b00, 8'h00, 8'h00, 1'b1);
    add_beat(2'b01, 8'hFF, 8'h00, 1'b0);
    add_beat(2'b10, 8'hFF, 8'h00, 1'b0);
    test_stream("mask");
  endtask

  task automatic test_mixed_ops();
    add_beat(2'b00, 8'hAA, 8'hFF, 1'b0);
    add_beat(2'b01, 8'hAA, 8'hFF, 1'b1);
    add_beat(2'b10, 8'hAA, 8'hFF, 1'b0);
    add_beat(2'b11, 8'hAA, 8'hFF, 1'b1);
    test_stream("mixed");
  endtask

  task automatic test_backpressure();
    int guard = 0;
    int stall = -1;
    logic [2:0] held = '0;
    logic [2:0] e;
    int c;
    add_beat(2'b01, 8'h00, 8'hFF, 1'b0);
    add_beat(2'b01, 8'h01, 8'hFF, 1'b1);
    add_beat(2'b01, 8'h80, 8'hFF, 1'b1);
    add_beat(2'b01, 8'hF0, 8'h0F, 1'b0);
    add_beat(2'b11, 8'hFF, 8'hFF, 1'b0);
    while ((stim_q.size() > 0 || exp_q.size() > 0) && guard < 200) begin
      @(negedge clk);
      if (stall < 0 && out_valid) begin
        stall = 5;
        held  = {out_op, out_result};
      end
      drive_cycle(!(stall > 0), 1'b1);
      if (stall > 0) begin
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_op, out_result} !== held) begin
          n_fail++;
          $display("FAIL bp_hold: got in_ready=%b v=%b op/r=%b, want 0 1 %b", in_ready, out_valid, {out_op, out_result}, held);
        end
        stall--;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra: unexpected beat op=%b r=%b", out_op, out_result);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          if ({out_op, out_result} !== e) begin
            n_fail++;
            $display("FAIL bp_result: got op=%b r=%b, want op=%b r=%b", out_op, out_result, e[2:1], e[0]);
          end
        end
      end
      guard++;
    end
    if (guard >= 200 || stall != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL bp_timeout: outstanding=%0d stall=%0d, want 0 0", exp_q.size(), stall);
    end
  endtask

  task automatic test_random();
    int guard = 0;
    logic [2:0] e;
    int c;
    logic [1:0] op;
    logic [N-1:0] d, m;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      d  = 8'($urandom_range(0, 255));
      m  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      add_beat(op, d, m, model(op, d, m));
    end
    while ((stim_q.size() > 0 || exp_q.size() > 0) && guard < 2000) begin
      @(negedge clk);
      drive_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: unexpected beat op=%b r=%b", out_op, out_result);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          if ({out_op, out_result} !== e) begin
            n_fail++;
            $display("FAIL rand_result: got op=%b r=%b, want op=%b r=%b (issued cycle %0d)", out_op, out_result, e[2:1], e[0], c);
          end
        end
      end
      guard++;
    end
    if (guard >= 2000) begin
      n_cmp++; n_fail++;
      $display("FAIL rand_timeout: %0d results outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int leaked = 0;
    for (int i = 0; i < 5; i++) add_beat(2'b00, 8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_cycle(1'b1, 1'b1);
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got out_valid=%b, want 1", out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_result !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_flush: got v=%b r=%b in_ready=%b, want 0 0 1", out_valid, out_result, in_ready);
    end
    in_valid = 1'b0;
    stim_q.delete();
    exp_q.delete();
    exp_cyc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_cycle(1'b1, 1'b1);
      if (out_valid !== 1'b0) leaked++;
    end
    n_cmp++;
    if (leaked != 0) begin
      n_fail++;
      $display("FAIL rstmid_leak: got %0d valid cycles after reset, want 0", leaked);
    end
    add_beat(2'b00, 8'hFF, 8'hFF, 1'b1);
    test_stream("rstmid_new");
  endtask

  initial begin
    test_reset();
    test_and();
    test_xor_stream();
    test_mask();
    test_mixed_ops();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
